custom_axi_regs: RTL and testbench

AXI4-Lite slave register file that drives the register-to-hardware interface of the custom IP core. It converts bus writes into the core's data word and one-cycle enable pulse, and exposes the core's output data and status back to the bus. It sits between the system interconnect and the core and is the bus-side end of the core's register interface.

---
 rtl/custom_axi_ip_pkg.sv | 25 ++
 rtl/custom_axi_regs_wr_ctrl.sv | 82 ++++++++
 rtl/custom_axi_regs.sv | 126 ++++++++++++
 tb/tb_custom_axi_regs.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_axi_ip_pkg.sv
// custom_axi_ip_pkg: shared core status codes, AXI response codes and register map of the custom IP core
package custom_axi_ip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } axi_resp_e;

    localparam logic [3:0] CTRL_OFF     = 4'h0;
    localparam logic [3:0] DATA_IN_OFF  = 4'h4;
    localparam logic [3:0] DATA_OUT_OFF = 4'h8;
    localparam logic [3:0] STATUS_OFF   = 4'hC;

    localparam int CTRL_START_BIT  = 0;
    localparam int STATUS_DONE_BIT = 2;
    localparam int STATUS_DROP_BIT = 3;

endpackage

// File: rtl/custom_axi_regs_wr_ctrl.sv
// custom_axi_regs_wr_ctrl: captures AW and W independently, issues one update strobe, then holds B until accepted
module custom_axi_regs_wr_ctrl
    import custom_axi_ip_pkg::OKAY;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [31:0]           s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic [3:0]            wr_strb_o
);

    typedef enum logic [1:0] {IDLE, HAVE_AW, HAVE_W, RESP} wr_state_e;

    wr_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                  aw_hs, w_hs, have_aw, have_w;

    always_comb begin
        aw_hs     = s_awvalid_i && awready_q;
        w_hs      = s_wvalid_i && wready_q;
        have_aw   = aw_hs || state_q == HAVE_AW;
        have_w    = w_hs || state_q == HAVE_W;
        awaddr_d  = aw_hs ? s_awaddr_i : awaddr_q;
        wdata_d   = w_hs ? s_wdata_i : wdata_q;
        wstrb_d   = w_hs ? s_wstrb_i : wstrb_q;
        bvalid_d  = bvalid_q;
        state_d   = (have_aw && have_w) ? RESP : have_aw ? HAVE_AW : have_w ? HAVE_W : IDLE;
        // RESP spends one cycle with bvalid low; that cycle carries the register update
        if (state_q == RESP) begin
            bvalid_d = !bvalid_q || !s_bready_i;
            state_d  = (bvalid_q && s_bready_i) ? IDLE : RESP;
        end
        awready_d = state_d == IDLE || state_d == HAVE_W;
        wready_d  = state_d == IDLE || state_d == HAVE_AW;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    assign s_awready_o = awready_q;
    assign s_wready_o  = wready_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_bresp_o   = OKAY;
    assign wr_en_o     = state_q == RESP && !bvalid_q;
    assign wr_addr_o   = awaddr_q;
    assign wr_data_o   = wdata_q;
    assign wr_strb_o   = wstrb_q;

endmodule

// File: rtl/custom_axi_regs.sv
// custom_axi_regs: AXI4-Lite register file bridging the interconnect to the custom IP core's data/start/status interface
module custom_axi_regs
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [31:0]           s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [31:0]           s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [31:0]           ipreg_data_o,
    output logic                  enable_o,
    input  logic [31:0]           ipreg_data_i,
    input  logic [1:0]            status_i
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("custom_axi_regs: DATA_WIDTH must be 32");
    end

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic [3:0]            wr_strb;
    logic [31:0]           data_in_q, data_in_d, rdata_q, rdata_d, status_word;
    logic                  done_sticky_q, done_sticky_d, start_drop_q, start_drop_d;
    logic                  enable_q, enable_d, rvalid_q, rvalid_d, arready_q, arready_d;
    logic [1:0]            status_prev_q;
    logic [3:0]            wr_sel, rd_sel;
    logic                  start_req, done_set, drop_set, clr_done, clr_drop, ar_hs;
    logic                  unused_ok;

    custom_axi_regs_wr_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .s_awaddr_i  (s_awaddr_i),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_wdata_i   (s_wdata_i),
        .s_wstrb_i   (s_wstrb_i),
        .s_wvalid_i  (s_wvalid_i),
        .s_wready_o  (s_wready_o),
        .s_bresp_o   (s_bresp_o),
        .s_bvalid_o  (s_bvalid_o),
        .s_bready_i  (s_bready_i),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .wr_strb_o   (wr_strb)
    );

    always_comb begin
        wr_sel        = {wr_addr[3:2], 2'b00};
        rd_sel        = {s_araddr_i[3:2], 2'b00};
        start_req     = wr_en && wr_sel == CTRL_OFF && wr_strb[0] && wr_data[CTRL_START_BIT];
        enable_d      = start_req && status_i == IDLE;
        drop_set      = start_req && status_i != IDLE;
        done_set      = status_i == DONE && status_prev_q != DONE;
        clr_done      = wr_en && wr_sel == STATUS_OFF && wr_strb[0] && wr_data[STATUS_DONE_BIT];
        clr_drop      = wr_en && wr_sel == STATUS_OFF && wr_strb[0] && wr_data[STATUS_DROP_BIT];
        // a set in the same cycle as a W1C clear wins
        done_sticky_d = done_set || (done_sticky_q && !clr_done);
        start_drop_d  = drop_set || (start_drop_q && !clr_drop);
        data_in_d     = data_in_q;
        for (int i = 0; i < 4; i++)
            if (wr_en && wr_sel == DATA_IN_OFF && wr_strb[i]) data_in_d[8*i +: 8] = wr_data[8*i +: 8];
        status_word                  = '0;
        status_word[1:0]             = status_i;
        status_word[STATUS_DONE_BIT] = done_sticky_q;
        status_word[STATUS_DROP_BIT] = start_drop_q;
        ar_hs         = s_arvalid_i && arready_q;
        rdata_d       = !ar_hs ? rdata_q :
                        rd_sel == DATA_IN_OFF  ? data_in_q :
                        rd_sel == DATA_OUT_OFF ? ipreg_data_i :
                        rd_sel == STATUS_OFF   ? status_word : '0;
        rvalid_d      = ar_hs || (rvalid_q && !s_rready_i);
        arready_d     = !rvalid_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_in_q     <= '0;
            done_sticky_q <= 1'b0;
            start_drop_q  <= 1'b0;
            enable_q      <= 1'b0;
            status_prev_q <= IDLE;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
        end else begin
            data_in_q     <= data_in_d;
            done_sticky_q <= done_sticky_d;
            start_drop_q  <= start_drop_d;
            enable_q      <= enable_d;
            status_prev_q <= status_i;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            arready_q     <= arready_d;
        end
    end

    assign s_arready_o  = arready_q;
    assign s_rvalid_o   = rvalid_q;
    assign s_rdata_o    = rdata_q;
    assign s_rresp_o    = OKAY;
    assign ipreg_data_o = data_in_q;
    assign enable_o     = enable_q;
    assign unused_ok    = ^{wr_addr, s_araddr_i};

endmodule

// File: tb/tb_custom_axi_regs.sv
// tb_custom_axi_regs: randomized self-checking bench for custom_axi_regs against a register-level reference model
module tb_custom_axi_regs;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic [3:0]  s_awaddr_i = '0, s_araddr_i = '0, s_wstrb_i = '0;
    logic        s_awvalid_i = 1'b0, s_wvalid_i = 1'b0, s_bready_i = 1'b0, s_arvalid_i = 1'b0, s_rready_i = 1'b0;
    logic [31:0] s_wdata_i = '0, ipreg_data_i = '0;
    logic [1:0]  status_i = 2'd0;
    logic        s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, enable_o;
    logic [1:0]  s_bresp_o, s_rresp_o;
    logic [31:0] s_rdata_o, ipreg_data_o;

    int total = 0, bad = 0, en_cnt = 0;
    logic [31:0] m_data = '0;
    bit m_done = 0, m_drop = 0;

    custom_axi_regs #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .ipreg_data_o(ipreg_data_o), .enable_o(enable_o), .ipreg_data_i(ipreg_data_i), .status_i(status_i)
    );

    always #5 clk_i = ~clk_i;
    always @(negedge clk_i) if (enable_o) en_cnt++;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] status_exp();
        return {28'd0, m_drop, m_done, status_i};
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        int cyc;
        bit aw_go, w_go;
        cyc = 0;
        @(negedge clk_i);
        s_awaddr_i = a; s_awvalid_i = 1; s_wdata_i = d; s_wstrb_i = s; s_wvalid_i = 1; s_bready_i = 1;
        while ((s_awvalid_i || s_wvalid_i) && cyc < 50) begin
            aw_go = s_awvalid_i && s_awready_o;
            w_go  = s_wvalid_i && s_wready_o;
            @(negedge clk_i);
            cyc++;
            if (aw_go) s_awvalid_i = 0;
            if (w_go) s_wvalid_i = 0;
        end
        while (!s_bvalid_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        resp = s_bresp_o;
        if (!s_bvalid_o) begin
            total++; bad++;
            $display("FAIL write_timeout addr=%h", a);
            s_awvalid_i = 0; s_wvalid_i = 0;
        end
        @(negedge clk_i);
        s_bready_i = 0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        cyc = 0;
        @(negedge clk_i);
        s_araddr_i = a; s_arvalid_i = 1;
        while (!s_arready_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        @(negedge clk_i);
        s_arvalid_i = 0; s_rready_i = 1;
        while (!s_rvalid_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        d = s_rdata_o; resp = s_rresp_o;
        if (!s_rvalid_o) begin
            total++; bad++;
            $display("FAIL read_timeout addr=%h", a);
        end
        @(negedge clk_i);
        s_rready_i = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        repeat (3) @(negedge clk_i);
        total++;
        if ({s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, enable_o} !== 6'b0) begin
            bad++; $display("FAIL reset_hs got=%b exp=000000", {s_awready_o, s_wready_o, s_bvalid_o, s_arready_o, s_rvalid_o, enable_o});
        end
        total++;
        if ({s_bresp_o, s_rresp_o, s_rdata_o, ipreg_data_o} !== 68'd0) begin
            bad++; $display("FAIL reset_data rdata=%h ipreg=%h bresp=%h rresp=%h", s_rdata_o, ipreg_data_o, s_bresp_o, s_rresp_o);
        end
        rst_ni = 1;
        repeat (2) @(negedge clk_i);
        total++;
        if ({s_awready_o, s_wready_o, s_arready_o} !== 3'b111) begin
            bad++; $display("FAIL ready_after_reset got=%b exp=111", {s_awready_o, s_wready_o, s_arready_o});
        end
        axi_read(4'hC, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
    endtask

    task automatic test_full_write();
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(4'h4, 32'hDEADBEEF, 4'hF, br);
        m_data = 32'hDEADBEEF;
        axi_read(4'h4, d, r);
        total++;
        if (d !== m_data) begin bad++; $display("FAIL full_write_rdata got=%h exp=%h", d, m_data); end
        total++;
        if (r !== 2'd0 || br !== 2'd0) begin bad++; $display("FAIL full_write_resp rresp=%h bresp=%h exp=0", r, br); end
        total++;
        if (ipreg_data_o !== m_data) begin bad++; $display("FAIL full_write_ipreg got=%h exp=%h", ipreg_data_o, m_data); end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(4'h4, 32'h11223344, 4'hF, br);
        axi_write(4'h4, 32'h0000AA00, 4'h2, br);
        m_data = 32'h1122AA44;
        axi_read(4'h4, d, r);
        total++;
        if (d !== m_data) begin bad++; $display("FAIL strobe_byte1 got=%h exp=%h", d, m_data); end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0] r;
        int bh;
        bit rdy_seen;
        @(negedge clk_i);
        total++;
        if (s_wready_o !== 1'b1) begin bad++; $display("FAIL wfirst_wready got=%b exp=1", s_wready_o); end
        s_wdata_i = 32'hCAFEF00D; s_wstrb_i = 4'hF; s_wvalid_i = 1; s_bready_i = 0;
        @(negedge clk_i);
        s_wvalid_i = 0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({s_awready_o, s_wready_o, s_bvalid_o} !== 3'b100) begin
            bad++; $display("FAIL wfirst_hold got=%b exp=100", {s_awready_o, s_wready_o, s_bvalid_o});
        end
        s_awaddr_i = 4'h4; s_awvalid_i = 1;
        @(negedge clk_i);
        s_awvalid_i = 0;
        rdy_seen = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (s_awready_o || s_wready_o) rdy_seen = 1;
        end
        total++;
        if (s_bvalid_o !== 1'b1 || rdy_seen) begin
            bad++; $display("FAIL bvalid_hold bvalid=%b ready_seen=%b exp bvalid=1 ready_seen=0", s_bvalid_o, rdy_seen);
        end
        s_bready_i = 1;
        bh = 0;
        repeat (5) begin
            if (s_bvalid_o && s_bready_i) bh++;
            @(negedge clk_i);
        end
        s_bready_i = 0;
        total++;
        if (bh !== 1) begin bad++; $display("FAIL single_b got=%0d exp=1", bh); end
        m_data = 32'hCAFEF00D;
        axi_read(4'h4, d, r);
        total++;
        if (d !== m_data) begin bad++; $display("FAIL wfirst_data got=%h exp=%h", d, m_data); end
    endtask

    task automatic test_start();
        logic [31:0] d;
        logic [1:0] r, br;
        status_i = 2'd0;
        en_cnt = 0;
        axi_write(4'h0, 32'h1, 4'h1, br);
        repeat (3) @(negedge clk_i);
        total++;
        if (en_cnt !== 1) begin bad++; $display("FAIL start_idle_pulse got=%0d exp=1", en_cnt); end
        status_i = 2'd1;
        en_cnt = 0;
        axi_write(4'h0, 32'h1, 4'h1, br);
        m_drop = 1;
        repeat (3) @(negedge clk_i);
        total++;
        if (en_cnt !== 0) begin bad++; $display("FAIL start_busy_pulse got=%0d exp=0", en_cnt); end
        axi_read(4'hC, d, r);
        total++;
        if (d !== status_exp()) begin bad++; $display("FAIL start_drop_status got=%h exp=%h", d, status_exp()); end
        axi_read(4'h0, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ctrl_reads_zero got=%h exp=0", d); end
    endtask

    task automatic test_done_sticky();
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(4'hC, 32'h8, 4'h1, br);
        m_drop = 0;
        axi_read(4'hC, d, r);
        total++;
        if (d !== status_exp()) begin bad++; $display("FAIL drop_w1c got=%h exp=%h", d, status_exp()); end
        @(negedge clk_i); status_i = 2'd2; m_done = 1;
        @(negedge clk_i); status_i = 2'd0;
        axi_read(4'hC, d, r);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL done_sticky got=%h exp=4", d); end
        // clear DONE_STICKY in the very cycle status re-enters DONE
        repeat (2) @(negedge clk_i);
        total++;
        if ({s_awready_o, s_wready_o} !== 2'b11) begin bad++; $display("FAIL race_ready got=%b exp=11", {s_awready_o, s_wready_o}); end
        s_awaddr_i = 4'hC; s_wdata_i = 32'h4; s_wstrb_i = 4'h1; s_awvalid_i = 1; s_wvalid_i = 1; s_bready_i = 1;
        @(negedge clk_i);
        s_awvalid_i = 0; s_wvalid_i = 0; status_i = 2'd2;
        repeat (2) @(negedge clk_i);
        s_bready_i = 0;
        axi_read(4'hC, d, r);
        total++;
        if (d !== status_exp()) begin bad++; $display("FAIL set_wins got=%h exp=%h", d, status_exp()); end
        @(negedge clk_i); status_i = 2'd0;
        axi_write(4'hC, 32'h4, 4'h1, br);
        m_done = 0;
        axi_read(4'hC, d, r);
        total++;
        if (d !== status_exp()) begin bad++; $display("FAIL done_w1c got=%h exp=%h", d, status_exp()); end
    endtask

    task automatic test_random();
        logic [31:0] d, wd, exp_d;
        logic [1:0] r, br, lo;
        logic [3:0] s;
        int op, exp_en;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 4);
            lo = 2'($urandom_range(0, 3));
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            if (op == 0) begin
                axi_write({2'b01, lo}, wd, s, br);
                m_data = merge(m_data, wd, s);
                total++;
                if (ipreg_data_o !== m_data || br !== 2'd0) begin
                    bad++; $display("FAIL rand_wr_data ipreg=%h exp=%h bresp=%h", ipreg_data_o, m_data, br);
                end
            end else if (op == 1 || op == 2) begin
                ipreg_data_i = $urandom;
                exp_d = (op == 1) ? m_data : ipreg_data_i;
                axi_read({op == 1 ? 2'b01 : 2'b10, lo}, d, r);
                total++;
                if (d !== exp_d || r !== 2'd0) begin
                    bad++; $display("FAIL rand_rd op=%0d got=%h exp=%h rresp=%h", op, d, exp_d, r);
                end
            end else if (op == 3) begin
                en_cnt = 0;
                exp_en = (s[0] && wd[0]) ? 1 : 0;
                axi_write({2'b00, lo}, wd, s, br);
                repeat (2) @(negedge clk_i);
                total++;
                if (en_cnt !== exp_en) begin bad++; $display("FAIL rand_start got=%0d exp=%0d", en_cnt, exp_en); end
            end else begin
                axi_write({2'b10, lo}, wd, s, br);
                total++;
                if (br !== 2'd0 || ipreg_data_o !== m_data) begin
                    bad++; $display("FAIL rand_ro_write bresp=%h ipreg=%h exp=%h", br, ipreg_data_o, m_data);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(4'h4, 32'h12345678, 4'hF, br);
        @(negedge clk_i);
        s_awaddr_i = 4'h4; s_wdata_i = 32'hA5A5A5A5; s_wstrb_i = 4'hF;
        s_awvalid_i = 1; s_wvalid_i = 1; s_bready_i = 0;
        s_araddr_i = 4'h4; s_arvalid_i = 1; s_rready_i = 0;
        @(negedge clk_i);
        s_awvalid_i = 0; s_wvalid_i = 0; s_arvalid_i = 0;
        repeat (2) @(negedge clk_i);
        total++;
        if ({s_bvalid_o, s_rvalid_o} !== 2'b11) begin bad++; $display("FAIL pre_reset_valid got=%b exp=11", {s_bvalid_o, s_rvalid_o}); end
        #2 rst_ni = 0;
        #1;
        total++;
        if ({s_bvalid_o, s_rvalid_o, enable_o, s_awready_o, s_arready_o} !== 5'b0 || ipreg_data_o !== 32'h0) begin
            bad++; $display("FAIL mid_reset valids=%b ipreg=%h exp 00000/0", {s_bvalid_o, s_rvalid_o, enable_o, s_awready_o, s_arready_o}, ipreg_data_o);
        end
        m_data = 0; m_done = 0; m_drop = 0;
        @(negedge clk_i);
        rst_ni = 1;
        axi_write(4'h4, 32'h600DF00D, 4'hF, br);
        m_data = 32'h600DF00D;
        axi_read(4'h4, d, r);
        total++;
        if (d !== m_data || br !== 2'd0) begin bad++; $display("FAIL post_reset_write got=%h exp=%h bresp=%h", d, m_data, br); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_strobes();
        test_w_before_aw();
        test_start();
        test_done_sticky();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
